clock_divider: RTL
==================

Name: clock_divider

Overview:
- Consumes the free-running system clock `Clk` and derives a programmable-rate timebase for the multicycle datapath and peripherals.
- Outputs:
  - `Tick`: a one-cycle clock-enable pulse.
  - `Clk_Div`: a divided square-wave observation signal.
- The divide ratio can be changed at run time; a new ratio only takes effect at a period boundary, so no period is ever shortened.
- Supports start/stop with graceful drain of the period in progress.

Parameters:
- DIV_WIDTH, 8: width of divide-ratio input and period counter.
- DIV_RESET, 2: divide ratio active after reset (must be ≥1).
- CNT_WIDTH, 16: width of the optional tick counter.

Ports:
- Clk  input  1  system clock, rising-edge active
- Resetn  input  1  asynchronous, active-low reset
- Enable  input  1  run request, level-sensitive
- Div  input  DIV_WIDTH  requested divide ratio N; 0 is treated as 1
- Load  input  1  capture Div as pending ratio (1-cycle strobe)
- Tick  output  1  clock-enable pulse, one Clk cycle wide
- Clk_Div  output  1  divided clock, registered
- Running  output  1  high in RUN and DRAIN
- Load_Ack  output  1  1-cycle pulse when pending ratio becomes effective
- Tick_Count  output  CNT_WIDTH  ticks since reset (optional feature)

Behaviour:
- One clock domain (Clk). Reset is asynchronous and active-low: Resetn=0 immediately forces all state low, independent of Clk.
- All outputs are registered. On reset:
  - Tick=0, Clk_Div=0, Running=0, Load_Ack=0, Tick_Count=0.
  - Period counter = 0, active ratio = DIV_RESET, pending flag = 0, state = IDLE.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: counter held at 0; Tick=0, Clk_Div=0. If Enable=1 at edge k, go to RUN at edge k.
  - RUN: counter increments each edge and wraps at N_eff-1 → 0.
    - The first Tick is high in the cycle following edge k+N_eff; later Ticks come every N_eff cycles.
    - If Enable=0 is sampled, go to DRAIN.
  - DRAIN: counting continues.
    - At the end of the current period the final Tick is still issued, then the FSM goes to IDLE on that same edge.
    - If Enable=1 is sampled before the boundary, return to RUN with no gap and no phase change.
- Running=1 exactly while state is RUN or DRAIN.
- Ratio handling:
  - N_eff = max(Div,1). N_eff=1 gives Tick constantly high in RUN.
  - Clk_Div rises with each Tick, stays high ceil(N_eff/2) cycles, then low floor(N_eff/2) cycles.
  - N_eff=1 gives Clk_Div constant 1 while running.
  - Clk_Div returns to 0 when IDLE is entered.
- Load protocol:
  - Load=1 captures Div into the pending register and sets the pending flag.
  - In IDLE, the pending value becomes active on the next edge and Load_Ack pulses.
  - In RUN or DRAIN, it becomes active on the edge where the next period starts (the same edge Tick rises); Load_Ack pulses in that cycle.
  - A second Load before application overwrites the pending value; only one Load_Ack is issued, for the last value.
  - Load coincident with a boundary edge is deferred to the following boundary.
- Simultaneous events: Enable falling and Load together → drain proceeds and the Load applies at the drain boundary.
- Reset asserted mid-period discards the period, the pending load and the active ratio (back to DIV_RESET).

Optional Feature:
- Macro: CLOCK_DIVIDER_TICK_COUNT_EN.
- Defined: Tick_Count increments on each Tick and wraps from 2^CNT_WIDTH-1 to 0. It is cleared only by Resetn.
- Undefined: the port remains and is tied to 0; no counter logic is generated.

Decomposition:
- Shared package clock_pkg holds:
  - The state typedef (IDLE/RUN/DRAIN).
  - Default DIV_WIDTH/CNT_WIDTH constants.
  - Helper constant for the minimum ratio (1).
- One sub-module, clock_div_counter, holds the period counter plus the boundary/half-period compare. The top level keeps the FSM, load logic and outputs.

Test Plan:
- Reset then Enable=1 with DIV_RESET=2 → Tick every 2 cycles, Clk_Div 1,0,1,0; Running=1 the edge after Enable.
- Load Div=5 mid-period of N=2 → old period completes; Load_Ack coincides with the first Tick of N=5; Clk_Div then high 3 / low 2.
- Div=0 and Div=1 loaded → Tick held high continuously; Clk_Div constant 1.
- Enable dropped 1 cycle into N=4 period → 3 more cycles, final Tick, then IDLE, Running=0, Clk_Div=0. Repeat with Enable reasserted during DRAIN → no missed Tick.
- Resetn pulsed low between edges mid-period with a pending Load → outputs 0 immediately; no Load_Ack afterwards; ratio back to 2.
- With CLOCK_DIVIDER_TICK_COUNT_EN, CNT_WIDTH=4, N=1 for 17 cycles → Tick_Count wraps 15→0 and reads 1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the programmable clock divider.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    localparam int DEF_DIV_WIDTH = 8;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int MIN_RATIO     = 1;

endpackage

// File: rtl/clock_div_counter.sv
// Period counter for the clock divider; flags the last cycle of a period
// and the point where the divided clock drops to its low half.
module clock_div_counter
    import clock_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] ratio,
    output logic                 at_wrap,
    output logic                 at_half
);

    logic [DIV_WIDTH-1:0] cnt_r;
    logic [DIV_WIDTH:0]   cnt_inc_s;
    logic [DIV_WIDTH:0]   ratio_inc_s;
    logic [DIV_WIDTH:0]   half_s;
    logic [DIV_WIDTH:0]   last_s;

    // ratio is never zero here, so last_s cannot underflow; half_s = ceil(ratio/2)
    always_comb begin
        cnt_inc_s   = {1'b0, cnt_r} + {{DIV_WIDTH{1'b0}}, 1'b1};
        ratio_inc_s = {1'b0, ratio} + {{DIV_WIDTH{1'b0}}, 1'b1};
        half_s      = {1'b0, ratio_inc_s[DIV_WIDTH:1]};
        last_s      = {1'b0, ratio} - {{DIV_WIDTH{1'b0}}, 1'b1};
        at_wrap     = ({1'b0, cnt_r} == last_s);
        at_half     = (cnt_inc_s == half_s) && !at_wrap;
    end

    // Counter held at zero while stopped, wraps on the last cycle of the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (!run) begin
            cnt_r <= '0;
        end else if (at_wrap) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_inc_s[DIV_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/clock_divider.sv
// Programmable clock divider: Tick enable pulse, Clk_Div observation clock,
// run/drain control and boundary-aligned ratio loads.
// Optional tick counter enabled by defining CLOCK_DIVIDER_TICK_COUNT_EN.
module clock_divider
    import clock_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH,
    parameter int DIV_RESET = 2,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 Enable,
    input  logic [DIV_WIDTH-1:0] Div,
    input  logic                 Load,
    output logic                 Tick,
    output logic                 Clk_Div,
    output logic                 Running,
    output logic                 Load_Ack,
    output logic [CNT_WIDTH-1:0] Tick_Count
);

    localparam logic [DIV_WIDTH-1:0] RATIO_RST = DIV_WIDTH'(DIV_RESET);
    localparam logic [DIV_WIDTH-1:0] RATIO_MIN = DIV_WIDTH'(MIN_RATIO);

    function automatic logic [DIV_WIDTH-1:0] eff_ratio(input logic [DIV_WIDTH-1:0] d);
        if (d < RATIO_MIN) begin
            eff_ratio = RATIO_MIN;
        end else begin
            eff_ratio = d;
        end
    endfunction

    state_t               state_r;
    logic [DIV_WIDTH-1:0] ratio_r;
    logic [DIV_WIDTH-1:0] pend_div_r;
    logic                 pend_r;
    logic                 tick_r;
    logic                 clk_div_r;
    logic                 running_r;
    logic                 load_ack_r;
    logic                 run_s;
    logic                 apply_s;
    logic                 at_wrap_s;
    logic                 at_half_s;

    // A pending ratio lands immediately when idle, otherwise only at a period boundary
    always_comb begin
        run_s = (state_r != ST_IDLE);
        if (state_r == ST_IDLE) begin
            apply_s = pend_r;
        end else begin
            apply_s = pend_r && at_wrap_s;
        end
    end

    clock_div_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_counter (
        .clk     (Clk),
        .rst_n   (Resetn),
        .run     (run_s),
        .ratio   (ratio_r),
        .at_wrap (at_wrap_s),
        .at_half (at_half_s)
    );

    // Pending ratio capture; a Load on the applying edge stays pending for the next boundary
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            pend_div_r <= '0;
            pend_r     <= 1'b0;
        end else if (Load) begin
            pend_div_r <= Div;
            pend_r     <= 1'b1;
        end else if (apply_s) begin
            pend_r     <= 1'b0;
        end else begin
            pend_r     <= pend_r;
        end
    end

    // Active ratio update and its acknowledge pulse
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ratio_r    <= RATIO_RST;
            load_ack_r <= 1'b0;
        end else begin
            load_ack_r <= apply_s;
            if (apply_s) begin
                ratio_r <= eff_ratio(pend_div_r);
            end else begin
                ratio_r <= ratio_r;
            end
        end
    end

    // Run/drain FSM with registered Tick, Clk_Div and Running
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= ST_IDLE;
            tick_r    <= 1'b0;
            clk_div_r <= 1'b0;
            running_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tick_r    <= 1'b0;
                    clk_div_r <= 1'b0;
                    if (Enable) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    tick_r <= at_wrap_s;
                    if (at_wrap_s && (state_r == ST_DRAIN) && !Enable) begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                        clk_div_r <= 1'b0;
                    end else begin
                        state_r   <= Enable ? ST_RUN : ST_DRAIN;
                        running_r <= 1'b1;
                        if (at_wrap_s) begin
                            clk_div_r <= 1'b1;
                        end else if (at_half_s) begin
                            clk_div_r <= 1'b0;
                        end else begin
                            clk_div_r <= clk_div_r;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tick_r    <= 1'b0;
                    clk_div_r <= 1'b0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_DIVIDER_TICK_COUNT_EN
    logic [CNT_WIDTH-1:0] tick_cnt_r;
    logic                 tick_next_s;

    always_comb begin
        tick_next_s = run_s && at_wrap_s;
    end

    // Counts every issued Tick; the count already includes the Tick being raised
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            tick_cnt_r <= '0;
        end else if (tick_next_s) begin
            tick_cnt_r <= tick_cnt_r + CNT_WIDTH'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    assign Tick_Count = tick_cnt_r;
`else
    assign Tick_Count = '0;
`endif

    assign Tick     = tick_r;
    assign Clk_Div  = clk_div_r;
    assign Running  = running_r;
    assign Load_Ack = load_ack_r;

endmodule
